// File: rtl/ones_frame_stats.sv
// Frame statistics over a stream of 16-bit-word ones counts: sum, max, min and an out-of-range flag.
// Optional min/max tracking is built only when ONES_FRAME_STATS_MINMAX_EN is defined.
module ones_frame_stats #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 5,
    parameter int SUM_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] count_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic [CNT_W-1:0] max_out,
    output logic [CNT_W-1:0] min_out,
    output logic             err_out,
    output logic [0:0]       fsm_state
);

    // Handshake: a word moves on an edge with in_valid && in_ready; a result moves on an
    // edge with out_valid && out_ready. in_ready is registered, out_valid decodes HOLD.
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(16);
    localparam logic [8:0]       LAST_CNT = 9'(FRAME_LEN);

    logic [0:0]       state;
    logic [SUM_W-1:0] sum_acc;
    logic [7:0]       wcnt;
    logic             err_acc;

    logic             accept;
    logic             over;
    logic             last;
    logic [CNT_W-1:0] clamped;
    logic [SUM_W-1:0] sum_next;

    assign accept    = in_valid && in_ready;
    assign over      = count_in > CNT_MAX;
    assign clamped   = over ? CNT_MAX : count_in;
    assign sum_next  = sum_acc + SUM_W'(clamped);
    assign last      = accept && !clear && (({1'b0, wcnt} + 9'd1) == LAST_CNT);
    assign out_valid = (state == HOLD);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ACCUM;
            in_ready <= 1'b0;
            sum_acc  <= '0;
            wcnt     <= '0;
            err_acc  <= 1'b0;
            sum_out  <= '0;
            err_out  <= 1'b0;
        end else if (state == HOLD) begin
            // clear is ignored here so a pending result is never lost
            if (out_ready) begin
                state    <= ACCUM;
                in_ready <= 1'b1;
            end
        end else if (clear) begin
            sum_acc  <= '0;
            wcnt     <= '0;
            err_acc  <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            in_ready <= !last;
            if (last) begin
                state   <= HOLD;
                sum_out <= sum_next;
                err_out <= err_acc | over;
                sum_acc <= '0;
                wcnt    <= '0;
                err_acc <= 1'b0;
            end else if (accept) begin
                sum_acc <= sum_next;
                wcnt    <= wcnt + 8'd1;
                err_acc <= err_acc | over;
            end
        end
    end

`ifdef ONES_FRAME_STATS_MINMAX_EN
    logic [CNT_W-1:0] max_acc;
    logic [CNT_W-1:0] min_acc;
    logic [CNT_W-1:0] max_next;
    logic [CNT_W-1:0] min_next;

    // The first word of a frame loads both trackers directly.
    assign max_next = (wcnt == 8'd0 || clamped > max_acc) ? clamped : max_acc;
    assign min_next = (wcnt == 8'd0 || clamped < min_acc) ? clamped : min_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_acc <= '0;
            min_acc <= '0;
            max_out <= '0;
            min_out <= '0;
        end else if (state == ACCUM) begin
            if (clear) begin
                max_acc <= '0;
                min_acc <= '0;
            end else if (last) begin
                max_out <= max_next;
                min_out <= min_next;
                max_acc <= '0;
                min_acc <= '0;
            end else if (accept) begin
                max_acc <= max_next;
                min_acc <= min_next;
            end
        end
    end
`else
    assign max_out = '0;
    assign min_out = '0;
`endif

endmodule
